// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types, limits and saturation helper for the pipelined CLA adder/subtractor
package cla_pkg;

   localparam int CLA_MAX_STAGES    = 8;
   localparam int CLA_DEFAULT_GROUP = 4;
   localparam int CLA_MAX_WIDTH     = 256;

   typedef struct packed {
      logic p;
      logic g;
   } cla_pg_t;

   // Most positive (neg=0) or most negative (neg=1) signed value of the given width.
   function automatic logic [CLA_MAX_WIDTH-1:0] cla_sat_value(input int width, input logic neg);
      logic [CLA_MAX_WIDTH-1:0] msb;
      msb = CLA_MAX_WIDTH'(1) << (width - 1);
      return neg ? msb : msb - CLA_MAX_WIDTH'(1);
   endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit lookahead adder with group propagate/generate
module cla_group
   import cla_pkg::*;
#(
   parameter int GROUP = CLA_DEFAULT_GROUP
) (
   input  logic [GROUP-1:0] a_i,
   input  logic [GROUP-1:0] b_i,
   input  logic             c_i,
   output logic [GROUP-1:0] s_o,
   output cla_pg_t          pg_o
);

   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP-1:0] c;

   assign p = a_i ^ b_i;
   assign g = a_i & b_i;

   always_comb begin
      c    = '0;
      c[0] = c_i;
      for (int i = 0; i < GROUP - 1; i++) begin
         c[i+1] = g[i] | (p[i] & c[i]);
      end
   end

   // Kept apart from the carry process so group P/G never depends on c_i.
   always_comb begin
      pg_o.p = &p;
      pg_o.g = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         pg_o.g = g[i] | (p[i] & pg_o.g);
      end
   end

   assign s_o = p ^ c;

endmodule

// File: rtl/cla_addsub_pipe.sv
// rtl/cla_addsub_pipe.sv - pipelined CLA add/sub with valid/ready backpressure
// Define CLA_ADDSUB_SAT_EN to clamp overflowing results to the signed limit.
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int GROUP  = CLA_DEFAULT_GROUP,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             of,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP;

   typedef struct packed {
      logic [WIDTH-1:0] psum;
      logic             carry;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   if ((STAGES < 1) || (STAGES > CLA_MAX_STAGES) || ((WIDTH % (GROUP * STAGES)) != 0)) begin : g_param_check
      $error("cla_addsub_pipe: need STAGES in 1..%0d and WIDTH a multiple of GROUP*STAGES", CLA_MAX_STAGES);
   end

   stage_t            in_s;
   stage_t            pipe [STAGES+1];
   logic [STAGES-1:0] stg_v;
   logic [STAGES:0]   vld;
   logic [STAGES:0]   rdy;
   logic              of_q;
   logic              zero_q;

   always_comb begin
      in_s       = '0;
      in_s.carry = cin ^ sub;
      in_s.a     = a;
      in_s.b     = sub ? ~b : b;
   end

   assign pipe[0] = in_s;
   assign vld[0]  = in_valid;

   // A stage can take new data when empty or when its occupant leaves this cycle.
   always_comb begin
      rdy         = '0;
      rdy[STAGES] = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         rdy[k] = !stg_v[k] || rdy[k+1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SW;

      stage_t           res_s;
      stage_t           ld_s;
      stage_t           pl_q;
      logic             valid_q;
      logic [NG:0]      gc;
      logic [SW-1:0]    gs;
      cla_pg_t [NG-1:0] gpg;

      for (genvar j = 0; j < NG; j++) begin : g_grp
         cla_group #(.GROUP(GROUP)) u_grp (
            .a_i  (pipe[k].a[LO + j*GROUP +: GROUP]),
            .b_i  (pipe[k].b[LO + j*GROUP +: GROUP]),
            .c_i  (gc[j]),
            .s_o  (gs[j*GROUP +: GROUP]),
            .pg_o (gpg[j])
         );
      end

      always_comb begin
         gc    = '0;
         gc[0] = pipe[k].carry;
         for (int j = 0; j < NG; j++) begin
            gc[j+1] = gpg[j].g | (gpg[j].p & gc[j]);
         end
      end

      always_comb begin
         res_s                = pipe[k];
         res_s.psum[LO +: SW] = gs;
         res_s.carry          = gc[NG];
      end

      if (k == STAGES - 1) begin : g_last
         logic of_d;
         logic zero_d;

         always_comb begin
            ld_s = res_s;
            of_d = (res_s.a[WIDTH-1] == res_s.b[WIDTH-1]) &&
                   (res_s.psum[WIDTH-1] != res_s.a[WIDTH-1]);
`ifdef CLA_ADDSUB_SAT_EN
            if (of_d) begin
               ld_s.psum = WIDTH'(cla_sat_value(WIDTH, res_s.a[WIDTH-1]));
            end
`endif
            zero_d = ~|ld_s.psum;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               of_q   <= 1'b0;
               zero_q <= 1'b0;
            end else if (rdy[k] && vld[k]) begin
               of_q   <= of_d;
               zero_q <= zero_d;
            end
         end
      end else begin : g_mid
         assign ld_s = res_s;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
         end else if (rdy[k]) begin
            valid_q <= vld[k];
            if (vld[k]) begin
               pl_q <= ld_s;
            end
         end
      end

      assign stg_v[k]  = valid_q;
      assign vld[k+1]  = valid_q;
      assign pipe[k+1] = pl_q;
   end

   assign in_ready  = rdy[0];
   assign out_valid = stg_v[STAGES-1];
   assign sum       = pipe[STAGES].psum;
   assign cout      = pipe[STAGES].carry;
   assign of        = of_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb/tb_cla_addsub_pipe.sv - directed self-checking bench for cla_addsub_pipe (default and 64-bit/4-stage builds)
module tb_cla_addsub_pipe;

`ifdef CLA_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, of, zero;
   logic [31:0] a, b, sum;
   logic        in_valid_w, in_ready_w, sub_w, cin_w, out_valid_w, out_ready_w, cout_w, of_w, zero_w;
   logic [63:0] a_w, b_w, sum_w;

   int checks = 0;
   int errors = 0;

   cla_addsub_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .cout(cout), .of(of), .zero(zero)
   );

   cla_addsub_pipe #(.WIDTH(64), .GROUP(8), .STAGES(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w), .a(a_w), .b(b_w),
      .sub(sub_w), .cin(cin_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .sum(sum_w),
      .cout(cout_w), .of(of_w), .zero(zero_w)
   );

   // Reference: {cout, of, zero, sum}
   function automatic logic [34:0] ref_op(input logic [31:0] ra, input logic [31:0] rb, input logic rsub, input logic rcin);
      logic [31:0] be;
      logic [32:0] t;
      logic [31:0] s;
      logic        o;
      be = rsub ? ~rb : rb;
      t  = {1'b0, ra} + {1'b0, be} + 33'(rcin ^ rsub);
      s  = t[31:0];
      o  = (ra[31] == be[31]) && (s[31] != ra[31]);
      if (SAT && o) s = ra[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return {t[32], o, (s == 32'h0), s};
   endfunction

   task automatic run_single(input logic [31:0] ta, input logic [31:0] tb, input logic ts, input logic tc,
                             output logic [31:0] rs, output logic rc, output logic ro, output logic rz, output int lat);
      @(negedge clk);
      a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rs = sum; rc = cout; ro = of; rz = zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({out_valid, cout, of, zero} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {out_valid, cout, of, zero}); end
      checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h expected 0", sum); end
      checks++; if ({out_valid_w, sum_w} !== 65'h0) begin errors++; $display("FAIL reset_wide: got %h expected 0", {out_valid_w, sum_w}); end
      rst_n = 1'b1;
      #1;
      checks++; if ({in_ready, in_ready_w} !== 2'b11) begin errors++; $display("FAIL reset_in_ready: got %b expected 11", {in_ready, in_ready_w}); end
   endtask

   task automatic test_add();
      logic [31:0] s; logic c, o, z; int lat;
      run_single(32'h5, 32'h3, 1'b0, 1'b0, s, c, o, z, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
      checks++; if (s !== 32'h8) begin errors++; $display("FAIL add_sum: got %h expected 00000008", s); end
      checks++; if ({c, o, z} !== 3'b000) begin errors++; $display("FAIL add_flags: got %b expected 000", {c, o, z}); end
      run_single(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
      checks++; if ({c, o, z, s} !== {3'b000, 32'h0001_0000}) begin errors++; $display("FAIL add_stage_carry: got %h expected %h", {c, o, z, s}, {3'b000, 32'h0001_0000}); end
   endtask

   task automatic test_overflow();
      logic [31:0] s; logic c, o, z; int lat;
      run_single(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
      checks++; if (s !== (SAT ? 32'h7FFF_FFFF : 32'h8000_0000)) begin errors++; $display("FAIL ovf_pos_sum: got %h expected %h", s, SAT ? 32'h7FFF_FFFF : 32'h8000_0000); end
      checks++; if ({c, o, z} !== 3'b010) begin errors++; $display("FAIL ovf_pos_flags: got %b expected 010", {c, o, z}); end
      run_single(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, s, c, o, z, lat);
      checks++; if (s !== (SAT ? 32'h8000_0000 : 32'h0)) begin errors++; $display("FAIL ovf_neg_sum: got %h expected %h", s, SAT ? 32'h8000_0000 : 32'h0); end
      checks++; if ({c, o, z} !== {2'b11, !SAT}) begin errors++; $display("FAIL ovf_neg_flags: got %b expected %b", {c, o, z}, {2'b11, !SAT}); end
   endtask

   task automatic test_subtract();
      logic [31:0] s; logic c, o, z; int lat;
      run_single(32'h4, 32'h4, 1'b1, 1'b0, s, c, o, z, lat);
      checks++; if (s !== 32'h0) begin errors++; $display("FAIL sub_zero_sum: got %h expected 0", s); end
      checks++; if ({c, o, z} !== 3'b101) begin errors++; $display("FAIL sub_zero_flags: got %b expected 101", {c, o, z}); end
      run_single(32'h4, 32'h4, 1'b1, 1'b1, s, c, o, z, lat);
      checks++; if ({c, o, z, s} !== {3'b000, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sub_borrow: got %h expected %h", {c, o, z, s}, {3'b000, 32'hFFFF_FFFF}); end
      run_single(32'h8000_0000, 32'h1, 1'b1, 1'b0, s, c, o, z, lat);
      checks++; if ({c, o, z, s} !== {3'b110, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF}) begin errors++; $display("FAIL sub_ovf: got %h expected %h", {c, o, z, s}, {3'b110, SAT ? 32'h8000_0000 : 32'h7FFF_FFFF}); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] va [10] = '{32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h10, 32'h0, 32'h1234_5678, 32'h8000_0000, 32'hAAAA_5555, 32'hDEAD_BEEF, 32'h0000_FFFF};
      logic [31:0] vb [10] = '{32'h2, 32'h1, 32'h7FFF_FFFF, 32'h3, 32'h1, 32'h8765_4321, 32'h7FFF_FFFF, 32'h5555_AAAA, 32'hDEAD_BEEF, 32'h1};
      logic        vs [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic        vc [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      logic [34:0] expq [$];
      logic [34:0] exp_r, held;
      logic        exp_rdy;
      int acc = 0, got = 0, cyc = 0;
      while (got < 10 && cyc < 200) begin
         @(negedge clk);
         out_ready = !(cyc >= 4 && cyc < 9);
         in_valid  = (acc < 10);
         if (acc < 10) begin a = va[acc]; b = vb[acc]; sub = vs[acc]; cin = vc[acc]; end
         #1;
         exp_rdy = ((acc - got) < 2) || out_ready;
         checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy); end
         if (cyc == 4) held = {cout, of, zero, sum};
         if (cyc > 4 && cyc < 9) begin
            checks++; if ({out_valid, cout, of, zero, sum} !== {1'b1, held}) begin errors++; $display("FAIL b2b_stall_hold cyc %0d: got %h expected %h", cyc, {out_valid, cout, of, zero, sum}, {1'b1, held}); end
         end
         if (out_valid && out_ready) begin
            exp_r = (expq.size() > 0) ? expq.pop_front() : 35'h0;
            checks++; if ({cout, of, zero, sum} !== exp_r) begin errors++; $display("FAIL b2b_result %0d: got %h expected %h", got, {cout, of, zero, sum}, exp_r); end
            got++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(ref_op(va[acc], vb[acc], vs[acc], vc[acc]));
            acc++;
         end
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got !== 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", got); end
   endtask

   task automatic test_wide();
      logic [63:0] wa [2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF};
      logic [66:0] wexp [2];
      int lat;
      wexp[0] = {3'b101, 64'h0};
      wexp[1] = {3'b010, SAT ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         a_w = wa[i]; b_w = 64'h1; sub_w = 1'b0; cin_w = 1'b0; in_valid_w = 1'b1; out_ready_w = 1'b1;
         @(negedge clk);
         in_valid_w = 1'b0;
         lat = 1;
         while (!out_valid_w && lat < 20) begin
            @(negedge clk);
            lat++;
         end
         checks++; if (lat !== 4) begin errors++; $display("FAIL wide_latency %0d: got %0d expected 4", i, lat); end
         checks++; if ({cout_w, of_w, zero_w, sum_w} !== wexp[i]) begin errors++; $display("FAIL wide_result %0d: got %h expected %h", i, {cout_w, of_w, zero_w, sum_w}, wexp[i]); end
      end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] s; logic c, o, z; int lat;
      @(negedge clk);
      out_ready = 1'b0; a = 32'h1; b = 32'h1; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 32'h2; b = 32'h2;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++; if ({out_valid, in_ready} !== 2'b10) begin errors++; $display("FAIL rst_mid_preload: got %b expected 10", {out_valid, in_ready}); end
      rst_n = 1'b0;
      #1;
      checks++; if ({out_valid, cout, of, zero, sum} !== 36'h0) begin errors++; $display("FAIL rst_mid_clear: got %h expected 0", {out_valid, cout, of, zero, sum}); end
      @(negedge clk);
      rst_n = 1'b1; out_ready = 1'b1;
      #1;
      checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL rst_mid_release: got %b expected 10", {in_ready, out_valid}); end
      run_single(32'h9, 32'h6, 1'b0, 1'b0, s, c, o, z, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 2", lat); end
      checks++; if (s !== 32'hF) begin errors++; $display("FAIL rst_mid_sum: got %h expected 0000000f", s); end
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_alone: got %b expected 0", out_valid); end
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
      in_valid_w = 1'b0; a_w = '0; b_w = '0; sub_w = 1'b0; cin_w = 1'b0; out_ready_w = 1'b1;
      test_reset();
      test_add();
      test_overflow();
      test_subtract();
      test_back_to_back();
      test_wide();
      test_reset_midflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
